// File: rtl/muldiv_issue_pkg.sv
// rtl/muldiv_issue_pkg.sv - shared MDU op codes, issue FSM states and op helpers
package muldiv_issue_pkg;

    localparam int MT_W = 3;

    localparam logic [MT_W-1:0] mtNone             = 3'd0;
    localparam logic [MT_W-1:0] mtMultiply         = 3'd1;
    localparam logic [MT_W-1:0] mtMultiplyUnsigned = 3'd2;
    localparam logic [MT_W-1:0] mtDivide           = 3'd3;
    localparam logic [MT_W-1:0] mtDivideUnsigned   = 3'd4;
    localparam logic [MT_W-1:0] mtMSUB             = 3'd5;
    localparam logic [MT_W-1:0] mtSetHI            = 3'd6;
    localparam logic [MT_W-1:0] mtSetLO            = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_BUSY = 2'd2
    } mdi_state_e;

    // Set-class ops are applied by the MDU on the start edge and never raise busy.
    function automatic logic is_set_op(input logic [MT_W-1:0] op);
        return (op == mtSetHI) || (op == mtSetLO);
    endfunction

endpackage

// File: rtl/muldiv_issue.sv
// rtl/muldiv_issue.sv - issue/interlock stage in front of the HI/LO multiply-divide unit
module muldiv_issue
    import muldiv_issue_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [OP_WIDTH-1:0]   ex_op,
    input  logic [DATA_WIDTH-1:0] ex_A,
    input  logic [DATA_WIDTH-1:0] ex_B,
    input  logic                  ex_readHI,
    input  logic                  ex_readLO,
    input  logic                  flush,
    input  logic                  md_busy,
    input  logic [DATA_WIDTH-1:0] md_HI,
    input  logic [DATA_WIDTH-1:0] md_LO,
    output logic                  md_start,
    output logic [OP_WIDTH-1:0]   md_ctrl,
    output logic [DATA_WIDTH-1:0] md_A,
    output logic [DATA_WIDTH-1:0] md_B,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    mdi_state_e            state_q, state_d;
    logic                  md_start_q, md_start_d;
    logic [OP_WIDTH-1:0]   md_ctrl_q, md_ctrl_d;
    logic [DATA_WIDTH-1:0] md_a_q, md_a_d;
    logic [DATA_WIDTH-1:0] md_b_q, md_b_d;
    logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;

    logic req, rd, quiet, accept, stall_w;

    // HI/LO are only trustworthy with nothing in flight, or once busy has dropped.
    always_comb begin
        req     = ex_valid & ~flush & (ex_op != OP_WIDTH'(mtNone));
        rd      = ex_valid & ~flush & (ex_readHI | ex_readLO);
        quiet   = (state_q == ST_IDLE) | ((state_q == ST_BUSY) & ~md_busy);
        accept  = req & quiet;
        stall_w = (req | rd) & ~quiet;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_PEND;
            end
            ST_PEND: begin
                state_d = is_set_op(MT_W'(md_ctrl_q)) ? ST_IDLE : ST_BUSY;
            end
            ST_BUSY: begin
                if (!md_busy) state_d = accept ? ST_PEND : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        md_start_d    = accept;
        md_ctrl_d     = md_ctrl_q;
        md_a_d        = md_a_q;
        md_b_d        = md_b_q;
        stall_count_d = stall_count_q;
        if (accept) begin
            md_ctrl_d = ex_op;
            md_a_d    = ex_A;
            md_b_d    = ex_B;
        end
        if (stall_w && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_start_q    <= 1'b0;
            md_ctrl_q     <= OP_WIDTH'(mtNone);
            md_a_q        <= '0;
            md_b_q        <= '0;
            stall_count_q <= '0;
        end else begin
            md_start_q    <= md_start_d;
            md_ctrl_q     <= md_ctrl_d;
            md_a_q        <= md_a_d;
            md_b_q        <= md_b_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign md_start    = md_start_q;
    assign md_ctrl     = md_ctrl_q;
    assign md_A        = md_a_q;
    assign md_B        = md_b_q;
    assign stall       = stall_w;
    assign rdata       = ex_readHI ? md_HI : md_LO;
    assign stall_count = stall_count_q;

endmodule

// File: doc/muldiv_issue.md
Name: muldiv_issue

Overview:
- Issue/interlock stage directly upstream of the HI/LO multiply-divide unit.
- Takes MDU requests and MFHI/MFLO reads from the EX stage, registers operands, and drives the unit's start/ctrl/A/B.
- Generates the pipeline stall that covers the one-cycle gap before the unit's busy becomes visible, and returns HI/LO read data.
- Counts stall cycles for performance monitoring.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width.
- OP_WIDTH, 3, width of MDU op code (shared mt* constants).
- CNT_WIDTH, 32, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX-stage instruction valid.
- ex_op  in  OP_WIDTH  MDU op (mt* code); mtNone = no MDU op.
- ex_A  in  DATA_WIDTH  rs operand.
- ex_B  in  DATA_WIDTH  rt operand.
- ex_readHI  in  1  instruction is MFHI.
- ex_readLO  in  1  instruction is MFLO.
- flush  in  1  kill current EX instruction.
- md_busy  in  1  busy from MDU.
- md_HI  in  DATA_WIDTH  HI from MDU.
- md_LO  in  DATA_WIDTH  LO from MDU.
- md_start  out  1  registered start pulse to MDU.
- md_ctrl  out  OP_WIDTH  registered op to MDU.
- md_A  out  DATA_WIDTH  registered operand A.
- md_B  out  DATA_WIDTH  registered operand B.
- stall  out  1  combinational stall request to pipeline.
- rdata  out  DATA_WIDTH  MFHI/MFLO result (md_HI if ex_readHI, else md_LO).
- stall_count  out  CNT_WIDTH  saturating count of stall cycles.

Behaviour:
- Reset (async): state=IDLE; md_start=0, md_ctrl=mtNone, md_A=md_B=0, stall_count=0. stall is combinational and reads 0 while reset is held.
- States:
  - IDLE: nothing in flight.
  - PEND: request sits in output register; md_start=1 this cycle.
  - BUSY: long op launched, waiting for md_busy to fall.
- quiet = (state==IDLE) | (state==BUSY & !md_busy).
- req = ex_valid & !flush & (ex_op!=mtNone). rd = ex_valid & !flush & (ex_readHI|ex_readLO).
- stall = (req|rd) & !quiet. flush forces stall=0.
- Accept when req & quiet: on the edge, load md_ctrl/md_A/md_B, set md_start=1, go to PEND.
- md_start is high for exactly one cycle per accepted request and low in every other cycle; md_A/md_B/md_ctrl hold their values.
- PEND always stalls any req/rd, because MDU state is not yet updated.
- PEND next state:
  - Set-class op (mtSetHI/mtSetLO), applied by the MDU at this edge: go to IDLE.
  - mul/div/MSUB class: go to BUSY.
- BUSY: stay while md_busy=1. When md_busy=0 (result written): go to IDLE, or to PEND if a new req is accepted that same cycle.
- rdata is combinational and is valid only when rd & !stall.
- Read latency: 0 when quiet; otherwise stall until quiet.
- MFHI/MFLO in the same instruction as req cannot occur; if both are asserted, req takes priority for accept and rd is ignored.
- flush does not abort an op already in PEND/BUSY; the MDU always completes.
- Divide by zero is issued unchanged; HI/LO contents are whatever the MDU produces.
- stall_count increments by 1 on every cycle with stall=1 and saturates at all-ones.
- Reset mid-operation: returns to IDLE immediately. The MDU is reset by the same signal, so no stale busy is tracked.

Decomposition:
- Shared constants package: mt* op codes (mtNone, mtMultiply, mtMultiplyUnsigned, mtDivide, mtDivideUnsigned, mtMSUB, mtSetHI, mtSetLO) and FSM state encodings. MDU and this block use the same include.
- Helper function is_set_op(op) lives in the package.
- No sub-module. The saturating counter stays inline; it is too small to split.

Test Plan:
- MULT with ex_A=7, ex_B=0xFFFFFFFD at cycle 0 -> stall=0 in cycle 0; md_start=1, md_ctrl=mtMultiply, md_A=7, md_B=0xFFFFFFFD in cycle 1 only.
- MULT then MFLO next cycle -> stall high from the MFLO cycle until the cycle md_busy is low. Then rdata=0xFFFFFFEB; a following MFHI gives 0xFFFFFFFF with no stall.
- MTHI 0x1234 then MFHI next cycle -> exactly 1 stall cycle, then rdata=0x1234; stall_count=1.
- DIV 100/7 followed immediately by DIVU 9/2 -> second stalls until first completes. Second md_start appears on the cycle after md_busy falls. Final HI=1, LO=4.
- flush asserted with MULT request -> no md_start, stall=0. flush during BUSY -> md_busy sequence unaffected and HI/LO updated.
- Assert reset while in BUSY -> md_start, md_ctrl, md_A, md_B and stall_count go to 0 without a clock edge. After release, a MFLO is not stalled.
